// File: rtl/pool_ctrl_pkg.sv
// Shared definitions for the pool sequencer: FSM encodings, FIFO sizing and
// validity-mask generation.
package pool_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FEED  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int FIFO_CNT_W     = $clog2(DEF_FIFO_DEPTH) + 1;

   // Column col is valid when it lies below the programmed column count.
   function automatic logic mask_bit(input int col, input int num_cols);
      return (col < num_cols);
   endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// Handshake and configuration bundle between the pool sequencer and its
// upstream producer, pool unit and downstream consumer.
interface pool_ctrl_if #(
   parameter int MAT_MUL_SIZE = 4,
   parameter int DWIDTH       = 8,
   parameter int MASK_WIDTH   = 4,
   parameter int ROW_CNT_W    = 8
);
   localparam int ROW_W  = MAT_MUL_SIZE * DWIDTH;
   localparam int NCOL_W = $clog2(MASK_WIDTH) + 1;

   logic                  start;
   logic                  enable_pool;
   logic [ROW_CNT_W-1:0]  num_rows;
   logic [NCOL_W-1:0]     num_valid_cols;
   logic                  in_valid;
   logic [ROW_W-1:0]      in_data;
   logic                  in_ready;
   logic                  pool_enable;
   logic                  pool_in_data_available;
   logic [ROW_W-1:0]      pool_inp_data;
   logic [MASK_WIDTH-1:0] pool_validity_mask;
   logic                  pool_out_data_available;
   logic [ROW_W-1:0]      pool_out_data;
   logic                  pool_done;
   logic                  out_valid;
   logic [ROW_W-1:0]      out_data;
   logic                  out_ready;
   logic                  busy;
   logic                  done;
   logic                  err_unexpected;

   modport slave (
      input  start, enable_pool, num_rows, num_valid_cols,
      input  in_valid, in_data,
      output in_ready,
      output pool_enable, pool_in_data_available, pool_inp_data, pool_validity_mask,
      input  pool_out_data_available, pool_out_data, pool_done,
      output out_valid, out_data,
      input  out_ready,
      output busy, done, err_unexpected
   );

   modport master (
      output start, enable_pool, num_rows, num_valid_cols,
      output in_valid, in_data,
      input  in_ready,
      input  pool_enable, pool_in_data_available, pool_inp_data, pool_validity_mask,
      output pool_out_data_available, pool_out_data, pool_done,
      input  out_valid, out_data,
      output out_ready,
      input  busy, done, err_unexpected
   );

endinterface

// File: rtl/pool_ctrl_fifo.sv
// Small synchronous FIFO holding pool results until the downstream accepts
// them; head is presented combinationally, occupancy is exported for credit.
module pool_ctrl_fifo
   import pool_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int CNT_W = FIFO_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests against occupancy; a full FIFO may still take a push
   // in the same cycle it is popped.
   always_comb begin
      do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
      do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/pool_ctrl.sv
// Pool sequencer: accepts matmul rows, issues them to the pool (or bypasses
// it) under a FIFO credit limit, buffers results and reports job completion.
module pool_ctrl
   import pool_ctrl_pkg::*;
#(
   parameter int MAT_MUL_SIZE = 4,
   parameter int DWIDTH       = 8,
   parameter int MASK_WIDTH   = 4,
   parameter int ROW_CNT_W    = 8,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       resetn,
   pool_ctrl_if.slave bus
);

   localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

   state_t                state_r;
   state_t                state_next_s;
   logic                  cfg_pool_r;
   logic                  cfg_pool_next_s;
   logic [ROW_CNT_W-1:0]  cfg_rows_r;
   logic [ROW_CNT_W-1:0]  rows_sent_r;
   logic [ROW_CNT_W-1:0]  rows_popped_r;
   logic [CNT_W-1:0]      in_flight_r;
   logic [CNT_W-1:0]      in_flight_next_s;
   logic [CNT_W-1:0]      fifo_count_s;
   logic [CNT_W:0]        credit_s;
   logic [MASK_WIDTH-1:0] mask_r;
   logic [MASK_WIDTH-1:0] mask_s;
   logic [ROW_W-1:0]      pool_data_r;
   logic [ROW_W-1:0]      push_data_s;
   logic [ROW_W-1:0]      fifo_head_s;
   logic                  pool_avail_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  pool_enable_r;
   logic                  err_r;
   logic                  start_acc_s;
   logic                  in_ready_s;
   logic                  accept_s;
   logic                  out_valid_s;
   logic                  pop_s;
   logic                  ret_ok_s;
   logic                  ret_bad_s;
   logic                  push_s;
   logic                  drain_ok_s;

   // Validity mask derived from the requested column count.
   always_comb begin
      mask_s = {MASK_WIDTH{1'b0}};
      for (int i = 0; i < MASK_WIDTH; i++) begin
         mask_s[i] = mask_bit(i, int'(bus.num_valid_cols));
      end
   end

   // Handshakes, credit check and FIFO push source. A pool return only counts
   // when a row is actually outstanding.
   always_comb begin
      start_acc_s = (state_r == ST_IDLE) && bus.start;
      credit_s    = {1'b0, in_flight_r} + {1'b0, fifo_count_s};
      in_ready_s  = (state_r == ST_FEED) && (rows_sent_r < cfg_rows_r) &&
                    (credit_s < CREDIT_MAX);
      accept_s    = in_ready_s && bus.in_valid;
      out_valid_s = (fifo_count_s != {CNT_W{1'b0}});
      pop_s       = out_valid_s && bus.out_ready;
      ret_ok_s    = bus.pool_out_data_available && (in_flight_r != {CNT_W{1'b0}});
      ret_bad_s   = bus.pool_out_data_available && (in_flight_r == {CNT_W{1'b0}});
      push_s      = ret_ok_s || (accept_s && !cfg_pool_r);
      if (ret_ok_s) begin
         push_data_s = bus.pool_out_data;
      end else begin
         push_data_s = bus.in_data;
      end
      if (start_acc_s) begin
         cfg_pool_next_s = bus.enable_pool;
      end else begin
         cfg_pool_next_s = cfg_pool_r;
      end
      case ({accept_s && cfg_pool_r, ret_ok_s})
         2'b10:   in_flight_next_s = in_flight_r + CNT_W'(1);
         2'b01:   in_flight_next_s = in_flight_r - CNT_W'(1);
         default: in_flight_next_s = in_flight_r;
      endcase
      drain_ok_s = (rows_popped_r == cfg_rows_r) &&
                   (in_flight_r == {CNT_W{1'b0}}) &&
                   !out_valid_s &&
                   (bus.pool_done || !cfg_pool_r);
   end

   // Job sequencing FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_acc_s) begin
               if (bus.num_rows == {ROW_CNT_W{1'b0}}) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_FEED;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FEED: begin
            if (rows_sent_r == cfg_rows_r) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_FEED;
            end
         end
         ST_DRAIN: begin
            if (drain_ok_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, latched job configuration and row accounting.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         cfg_pool_r    <= 1'b0;
         cfg_rows_r    <= {ROW_CNT_W{1'b0}};
         mask_r        <= {MASK_WIDTH{1'b0}};
         rows_sent_r   <= {ROW_CNT_W{1'b0}};
         rows_popped_r <= {ROW_CNT_W{1'b0}};
         in_flight_r   <= {CNT_W{1'b0}};
      end else begin
         state_r    <= state_next_s;
         cfg_pool_r <= cfg_pool_next_s;
         if (start_acc_s) begin
            cfg_rows_r    <= bus.num_rows;
            mask_r        <= mask_s;
            rows_sent_r   <= {ROW_CNT_W{1'b0}};
            rows_popped_r <= {ROW_CNT_W{1'b0}};
            in_flight_r   <= {CNT_W{1'b0}};
         end else begin
            if (accept_s) begin
               rows_sent_r <= rows_sent_r + ROW_CNT_W'(1);
            end
            if (pop_s) begin
               rows_popped_r <= rows_popped_r + ROW_CNT_W'(1);
            end
            in_flight_r <= in_flight_next_s;
         end
      end
   end

   // Registered status and pool-side outputs; status flags follow the next state
   // so they line up with the state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         pool_enable_r <= 1'b0;
         pool_avail_r  <= 1'b0;
         pool_data_r   <= {ROW_W{1'b0}};
         err_r         <= 1'b0;
      end else begin
         busy_r        <= (state_next_s != ST_IDLE);
         done_r        <= (state_next_s == ST_DONE);
         pool_enable_r <= (state_next_s != ST_IDLE) && cfg_pool_next_s;
         pool_avail_r  <= accept_s && cfg_pool_r;
         if (accept_s && cfg_pool_r) begin
            pool_data_r <= bus.in_data;
         end
         if (ret_bad_s) begin
            err_r <= 1'b1;
         end else if (start_acc_s) begin
            err_r <= 1'b0;
         end
      end
   end

   pool_ctrl_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .count     (fifo_count_s)
   );

   assign bus.in_ready               = in_ready_s;
   assign bus.pool_enable            = pool_enable_r;
   assign bus.pool_in_data_available = pool_avail_r;
   assign bus.pool_inp_data          = pool_data_r;
   assign bus.pool_validity_mask     = mask_r;
   assign bus.out_valid              = out_valid_s;
   assign bus.out_data               = fifo_head_s;
   assign bus.busy                   = busy_r;
   assign bus.done                   = done_r;
   assign bus.err_unexpected         = err_r;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed testbench for pool_ctrl with a 3-cycle pool model that returns
// each issued row XORed with a fixed key.
module tb_pool_ctrl;

   localparam logic [31:0] XK = 32'h5A5A_A5A5;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   pool_ctrl_if ifc ();
   pool_ctrl dut (.clk(clk), .resetn(resetn), .bus(ifc));

   logic        pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0, inj = 1'b0;
   logic [31:0] pd0 = 32'h0, pd1 = 32'h0, pd2 = 32'h0;

   // Pool model: fixed 3-cycle latency, not reset by the controller's reset.
   always @(posedge clk) begin
      pv0 <= ifc.pool_in_data_available;
      pd0 <= ifc.pool_inp_data ^ XK;
      pv1 <= pv0;
      pd1 <= pd0;
      pv2 <= pv1;
      pd2 <= pd1;
   end
   assign ifc.pool_out_data_available = pv2 | inj;
   assign ifc.pool_out_data           = pd2;
   assign ifc.pool_done               = ~(pv0 | pv1 | pv2);

   int n_assert = 0, n_fail = 0;
   int cyc, n_acc, n_pop, n_issue, done_cnt, done_cyc;
   bit seen_ready;
   logic [31:0] pop_log [16];
   int pop_cyc [16];
   int acc_cyc [16];

   function automatic logic [31:0] row_val(input int i);
      return 32'hC0DE_0000 + 32'(i * 17);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      bit acc, pop;
      logic [31:0] od;
      acc = ifc.in_valid && ifc.in_ready;
      pop = ifc.out_valid && ifc.out_ready;
      od  = ifc.out_data;
      tick();
      cyc++;
      if (acc) begin
         if (n_acc < 16) acc_cyc[n_acc] = cyc;
         n_acc++;
         ifc.in_data = row_val(n_acc);
      end
      if (pop) begin
         if (n_pop < 16) begin
            pop_log[n_pop] = od;
            pop_cyc[n_pop] = cyc;
         end
         n_pop++;
      end
      if (ifc.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (ifc.pool_in_data_available) n_issue++;
      if (ifc.in_ready) seen_ready = 1'b1;
   endtask

   task automatic start_job(input bit pool, input int rows, input int cols);
      cyc = 0; n_acc = 0; n_pop = 0; n_issue = 0; done_cnt = 0; done_cyc = -1;
      seen_ready = 1'b0;
      ifc.enable_pool    = pool;
      ifc.num_rows       = 8'(rows);
      ifc.num_valid_cols = 3'(cols);
      ifc.in_data        = row_val(0);
      ifc.start          = 1'b1;
      cycle();
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         cycle();
         if (ifc.done) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      ifc.start = 1'b0; ifc.enable_pool = 1'b0; ifc.num_rows = 8'd0;
      ifc.num_valid_cols = 3'd0; ifc.in_valid = 1'b0; ifc.in_data = 32'h0;
      ifc.out_ready = 1'b0;
      #1 resetn = 1'b0;
      #1;
      n_assert++;
      if ({ifc.busy, ifc.done, ifc.in_ready, ifc.out_valid, ifc.pool_enable,
           ifc.pool_in_data_available, ifc.err_unexpected} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000", {ifc.busy, ifc.done, ifc.in_ready,
                  ifc.out_valid, ifc.pool_enable, ifc.pool_in_data_available, ifc.err_unexpected});
      end
      n_assert++;
      if (ifc.pool_validity_mask !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mask: got %b expected 0000", ifc.pool_validity_mask);
      end
      n_assert++;
      if (ifc.pool_inp_data !== 32'h0 || ifc.out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h expected 0/0", ifc.pool_inp_data, ifc.out_data);
      end
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      tick();
      n_assert++;
      if (ifc.busy !== 1'b0 || ifc.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b in_ready=%b expected 0/0", ifc.busy, ifc.in_ready);
      end
   endtask

   task automatic test_bypass();
      bit got;
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      start_job(1'b0, 3, 4);
      n_assert++;
      if (ifc.busy !== 1'b1 || ifc.pool_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_start: busy=%b pool_enable=%b expected 1/0", ifc.busy, ifc.pool_enable);
      end
      wait_done(40, got);
      n_assert++;
      if (!got) begin
         n_fail++;
         $display("FAIL byp_done_timeout: done seen=%0d expected 1", got);
      end
      n_assert++;
      if (n_acc != 3 || n_issue != 0) begin
         n_fail++;
         $display("FAIL byp_counts: acc=%0d issue=%0d expected 3/0", n_acc, n_issue);
      end
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (pop_log[i] !== row_val(i) || pop_cyc[i] != acc_cyc[i] + 1) begin
            n_fail++;
            $display("FAIL byp_row%0d: data=%h pop_cyc=%0d expected %h/%0d", i, pop_log[i],
                     pop_cyc[i], row_val(i), acc_cyc[i] + 1);
         end
      end
      n_assert++;
      if (done_cyc != pop_cyc[2] + 1 || ifc.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL byp_done_time: cyc=%0d busy=%b expected %0d/1", done_cyc, ifc.busy,
                  pop_cyc[2] + 1);
      end
      cycle();
      n_assert++;
      if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_busy_drop: busy=%b done=%b expected 0/0", ifc.busy, ifc.done);
      end
      repeat (3) cycle();
      n_assert++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL byp_done_once: pulses=%0d expected 1", done_cnt);
      end
      ifc.in_valid = 1'b0;
   endtask

   task automatic test_pool_backpressure();
      bit got;
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b1;
      start_job(1'b1, 6, 4);
      n_assert++;
      if (ifc.pool_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL pool_enable: got %b expected 1", ifc.pool_enable);
      end
      repeat (20) cycle();
      n_assert++;
      if (n_acc != 4 || n_issue != 4 || ifc.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pool_credit: acc=%0d issue=%0d in_ready=%b expected 4/4/0", n_acc,
                  n_issue, ifc.in_ready);
      end
      n_assert++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== (row_val(0) ^ XK)) begin
         n_fail++;
         $display("FAIL pool_head: valid=%b data=%h expected 1/%h", ifc.out_valid, ifc.out_data,
                  row_val(0) ^ XK);
      end
      ifc.out_ready = 1'b1;
      wait_done(60, got);
      n_assert++;
      if (!got || n_acc != 6 || n_pop != 6 || n_issue != 6) begin
         n_fail++;
         $display("FAIL pool_finish: done=%0d acc=%0d pop=%0d issue=%0d expected 1/6/6/6", got,
                  n_acc, n_pop, n_issue);
      end
      for (int i = 0; i < 6; i++) begin
         n_assert++;
         if (pop_log[i] !== (row_val(i) ^ XK)) begin
            n_fail++;
            $display("FAIL pool_row%0d: got %h expected %h", i, pop_log[i], row_val(i) ^ XK);
         end
      end
      n_assert++;
      if (done_cyc != pop_cyc[5] + 1) begin
         n_fail++;
         $display("FAIL pool_done_time: cyc=%0d expected %0d", done_cyc, pop_cyc[5] + 1);
      end
      ifc.in_valid = 1'b0;
      cycle();
   endtask

   task automatic test_mask();
      int          cols_t [3] = '{2, 0, 7};
      logic [3:0]  exp_t  [3] = '{4'b0011, 4'b0000, 4'b1111};
      for (int k = 0; k < 3; k++) begin
         start_job(1'b1, 0, cols_t[k]);
         n_assert++;
         if (ifc.pool_validity_mask !== exp_t[k]) begin
            n_fail++;
            $display("FAIL mask_cols%0d: got %b expected %b", cols_t[k], ifc.pool_validity_mask,
                     exp_t[k]);
         end
         cycle();
      end
   endtask

   task automatic test_zero_rows();
      ifc.in_valid = 1'b1;
      start_job(1'b1, 0, 4);
      n_assert++;
      if (ifc.done !== 1'b1 || ifc.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: done=%b busy=%b expected 1/1", ifc.done, ifc.busy);
      end
      cycle();
      n_assert++;
      if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle: done=%b busy=%b expected 0/0", ifc.done, ifc.busy);
      end
      repeat (3) cycle();
      n_assert++;
      if (seen_ready || n_issue != 0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL zero_quiet: ready=%0d issue=%0d pulses=%0d expected 0/0/1", seen_ready,
                  n_issue, done_cnt);
      end
      ifc.in_valid = 1'b0;
   endtask

   task automatic test_unexpected();
      repeat (4) tick();
      inj = 1'b1;
      tick();
      inj = 1'b0;
      n_assert++;
      if (ifc.err_unexpected !== 1'b1 || ifc.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL unexp_set: err=%b out_valid=%b expected 1/0", ifc.err_unexpected,
                  ifc.out_valid);
      end
      repeat (3) tick();
      n_assert++;
      if (ifc.err_unexpected !== 1'b1) begin
         n_fail++;
         $display("FAIL unexp_sticky: got %b expected 1", ifc.err_unexpected);
      end
      start_job(1'b0, 0, 4);
      n_assert++;
      if (ifc.err_unexpected !== 1'b0) begin
         n_fail++;
         $display("FAIL unexp_clear: got %b expected 0", ifc.err_unexpected);
      end
      cycle();
   endtask

   task automatic test_reset_midjob();
      bit got;
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      start_job(1'b1, 5, 4);
      for (int i = 0; i < 20 && n_acc < 2; i++) cycle();
      n_assert++;
      if (n_acc != 2) begin
         n_fail++;
         $display("FAIL mid_accept: got %0d expected 2", n_acc);
      end
      #2 resetn = 1'b0;
      #1;
      n_assert++;
      if ({ifc.busy, ifc.done, ifc.in_ready, ifc.out_valid, ifc.pool_enable,
           ifc.pool_in_data_available, ifc.err_unexpected} !== 7'b0 ||
          ifc.pool_validity_mask !== 4'b0000 || ifc.pool_inp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_async: flags=%b mask=%b pdata=%h expected all 0",
                  {ifc.busy, ifc.done, ifc.in_ready, ifc.out_valid, ifc.pool_enable,
                   ifc.pool_in_data_available, ifc.err_unexpected},
                  ifc.pool_validity_mask, ifc.pool_inp_data);
      end
      tick();
      tick();
      resetn = 1'b1;
      repeat (4) tick();
      n_assert++;
      if (ifc.err_unexpected !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_late_strobe: err=%b out_valid=%b busy=%b expected 1/0/0",
                  ifc.err_unexpected, ifc.out_valid, ifc.busy);
      end
      start_job(1'b1, 5, 3);
      wait_done(80, got);
      n_assert++;
      if (!got || n_acc != 5 || n_pop != 5 || n_issue != 5 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL mid_rerun: done=%0d acc=%0d pop=%0d issue=%0d pulses=%0d expected 1/5/5/5/1",
                  got, n_acc, n_pop, n_issue, done_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         n_assert++;
         if (pop_log[i] !== (row_val(i) ^ XK)) begin
            n_fail++;
            $display("FAIL mid_row%0d: got %h expected %h", i, pop_log[i], row_val(i) ^ XK);
         end
      end
      n_assert++;
      if (ifc.err_unexpected !== 1'b0 || ifc.pool_validity_mask !== 4'b0111) begin
         n_fail++;
         $display("FAIL mid_clean: err=%b mask=%b expected 0/0111", ifc.err_unexpected,
                  ifc.pool_validity_mask);
      end
      ifc.in_valid = 1'b0;
      cycle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_pool_backpressure();
      test_mask();
      test_zero_rows();
      test_unexpected();
      test_reset_midjob();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached with %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
- Sequencer and flow-control wrapper in front of the pool unit.
- Accepts output rows from the matmul with a valid/ready handshake, issues them to the pool one row per cycle with a generated validity mask, and collects pool results into a small output FIFO.
- Presents pool results downstream with valid/ready; pool output cannot be back-pressured, so the block issues credit-limited rows.
- Signals completion when a programmed number of rows has fully drained.
- Supports bypass when pooling is disabled.

Parameters:
- MAT_MUL_SIZE, 4, elements per row.
- DWIDTH, 8, bits per element.
- MASK_WIDTH, 4, validity mask width (= MAT_MUL_SIZE).
- ROW_CNT_W, 8, width of row counters.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins a job
- enable_pool  in  1  1 = route through pool; 0 = bypass (latched at start)
- num_rows  in  ROW_CNT_W  rows in job (latched at start)
- num_valid_cols  in  $clog2(MASK_WIDTH)+1  valid columns per row (latched at start)
- in_valid  in  1  upstream row valid
- in_data  in  MAT_MUL_SIZE*DWIDTH  upstream row
- in_ready  out  1  row accepted when in_valid&&in_ready
- pool_enable  out  1  drives pool enable_pool
- pool_in_data_available  out  1  row strobe to pool
- pool_inp_data  out  MAT_MUL_SIZE*DWIDTH  row to pool
- pool_validity_mask  out  MASK_WIDTH  mask to pool
- pool_out_data_available  in  1  pool result strobe
- pool_out_data  in  MAT_MUL_SIZE*DWIDTH  pool result
- pool_done  in  1  pool idle/complete level
- out_valid  out  1  downstream row valid (FIFO non-empty)
- out_data  out  MAT_MUL_SIZE*DWIDTH  FIFO head
- out_ready  in  1  downstream accept
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err_unexpected  out  1  sticky; pool result arrived with zero in-flight rows

Behaviour:
- Reset: all outputs 0. State IDLE, all counters 0, FIFO empty, latched config 0, err_unexpected 0.
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE -> FEED on start; if latched num_rows==0, go IDLE -> DONE instead.
  - FEED -> DRAIN when rows_sent==num_rows.
  - DRAIN -> DONE when rows_popped==num_rows, in_flight==0, FIFO empty, and (pool_done or bypass).
  - DONE -> IDLE after one cycle.
- start is ignored unless in IDLE.
- busy = (state != IDLE). done = 1 only in DONE.
- Credit rule: in_ready = (state==FEED) && (rows_sent < num_rows) && (in_flight + fifo_count < FIFO_DEPTH). fifo_count is the current registered value; a simultaneous pop does not add credit in the same cycle.
- Pool mode, on accept:
  - Register in_data to pool_inp_data; pulse pool_in_data_available the next cycle.
  - Increment rows_sent and in_flight.
  - On pool_out_data_available: push pool_out_data into FIFO and decrement in_flight.
  - Simultaneous issue and return leave in_flight unchanged.
- Bypass mode: an accepted row is pushed directly into the FIFO (1-cycle latency to out_valid). pool_in_data_available stays 0; in_flight is unused.
- pool_enable = latched enable_pool while busy, else 0.
- pool_validity_mask: bit i = (i < num_valid_cols). Values >= MASK_WIDTH give all ones; 0 gives all zeros. Held constant for the job.
- FIFO:
  - Pop on out_valid && out_ready; increment rows_popped.
  - Push and pop may occur in the same cycle.
  - Push when full cannot occur by the credit rule.
  - Ignore pool_out_data_available when in_flight==0 (no push) and set err_unexpected. It is cleared only by reset or start.
- Counters are ROW_CNT_W bits and never wrap within a job (max num_rows = 2^ROW_CNT_W-1).
- Reset mid-job: immediate return to IDLE. FIFO contents and in-flight results are discarded; late pool strobes after reset set err_unexpected.

Decomposition:
- Shared package pool_ctrl_pkg holds:
  - FSM state encodings (2-bit typedef).
  - Localparam for the FIFO count width.
  - Mask-generation function.
- One sub-module: pool_ctrl_fifo (synchronous FIFO, width MAT_MUL_SIZE*DWIDTH, depth FIFO_DEPTH, count output, async active-low reset).

Test Plan:
- Bypass, num_rows=3, in_valid held 1, out_ready=1 -> rows appear on out_data in order, 1 cycle after accept; done pulses once; busy drops the cycle after done.
- Pool mode, num_rows=6, pool model with 3-cycle latency, out_ready=0 -> in_ready deasserts after exactly 4 rows issued (FIFO_DEPTH). Raise out_ready -> remaining 2 rows flow; done after the 6th pop.
- num_valid_cols=2, 0, 7 -> pool_validity_mask = 4'b0011, 4'b0000, 4'b1111 respectively.
- num_rows=0 with start -> done pulses 1 cycle after start; in_ready never asserts; no pool strobes.
- Pool returns strobe with no row issued -> err_unexpected=1 sticky, FIFO count unchanged. Next start clears it.
- Assert resetn=0 mid-FEED after 2 of 5 rows -> all outputs 0 asynchronously. A new start after release completes a 5-row job cleanly.
